// File: rtl/adc_multichannel_stream.sv
// ADC capture back end: per-channel box-car decimation, set FIFO and an
// AXI-Stream serialiser with channel tag, TLAST framing and clip flags.
module adc_multichannel_stream #(
  parameter int N_CHANNELS       = 2,
  parameter int ZMOD_DATA_SIZE   = 14,
  parameter int AXIS_DATA_SIZE   = 32,
  parameter int DECIM_LOG2       = 0,
  parameter int FIFO_DEPTH       = 16,
  parameter int FRAME_SETS       = 256,
  parameter int IAGC_STATUS_SIZE = 4,
  localparam int UW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                               i_sys_clock,
  input  logic                               i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0]        i_iagc_status,
  input  logic [N_CHANNELS*ZMOD_DATA_SIZE-1:0] i_adc_data,
  input  logic                               i_adc_valid,
  input  logic                               i_clip_clear,
  output logic [AXIS_DATA_SIZE-1:0]          o_axis_tdata,
  output logic [UW-1:0]                      o_axis_tuser,
  output logic                               o_axis_tvalid,
  input  logic                               i_axis_tready,
  output logic                               o_axis_tlast,
  output logic [N_CHANNELS-1:0]              o_clip,
  output logic                               o_overflow,
  output logic [LW-1:0]                      o_fifo_level
);

  localparam int Z  = ZMOD_DATA_SIZE;
  localparam int AW = Z + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = (FRAME_SETS > 1) ? $clog2(FRAME_SETS) : 1;
  localparam int SW = N_CHANNELS * Z;
  localparam bit ONE_CH = (N_CHANNELS == 1);
  localparam logic [CW-1:0] WIN_LAST = CW'((1 << DECIM_LOG2) - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_SETS - 1);
  localparam logic [UW-1:0] CH_LAST = UW'(N_CHANNELS - 1);
  localparam logic [Z-1:0] S_MAX = {1'b0, {(Z-1){1'b1}}};
  localparam logic [Z-1:0] S_MIN = {1'b1, {(Z-1){1'b0}}};

  typedef enum logic {S_IDLE, S_SEND} state_t;

  function automatic logic [AXIS_DATA_SIZE-1:0] sext(input logic [Z-1:0] w);
    return AXIS_DATA_SIZE'(signed'(w));
  endfunction

  logic                 soft_clr;
  logic [CW-1:0]        win;
  logic signed [AW-1:0] acc [N_CHANNELS];
  logic signed [AW-1:0] sum [N_CHANNELS];
  logic [SW-1:0]        avg_set;
  logic [SW-1:0]        dec_set;
  logic                 dec_vld;

  assign soft_clr = (i_iagc_status == '0);

  always_comb begin
    avg_set = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      sum[k] = acc[k] + AW'(signed'(i_adc_data[k*Z +: Z]));
      avg_set[k*Z +: Z] = Z'(sum[k] >>> DECIM_LOG2);
    end
  end

  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n || soft_clr) begin
      win     <= '0;
      dec_vld <= 1'b0;
      dec_set <= '0;
      for (int k = 0; k < N_CHANNELS; k++) acc[k] <= '0;
    end else begin
      dec_vld <= 1'b0;
      if (i_adc_valid) begin
        if (win == WIN_LAST) begin
          win     <= '0;
          dec_vld <= 1'b1;
          dec_set <= avg_set;
          for (int k = 0; k < N_CHANNELS; k++) acc[k] <= '0;
        end else begin
          win <= win + CW'(1);
          for (int k = 0; k < N_CHANNELS; k++) acc[k] <= sum[k];
        end
      end
    end
  end

  // A new full-scale hit outranks a simultaneous clear request
  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n || soft_clr) begin
      o_clip <= '0;
    end else begin
      for (int k = 0; k < N_CHANNELS; k++) begin
        if (i_adc_valid && (i_adc_data[k*Z +: Z] == S_MAX ||
                            i_adc_data[k*Z +: Z] == S_MIN))
          o_clip[k] <= 1'b1;
        else if (i_clip_clear)
          o_clip[k] <= 1'b0;
      end
    end
  end

  state_t        state;
  logic [SW-1:0] set_q;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_nxt;
  logic [UW-1:0] ch_nxt;
  logic [Z-1:0]  nxt_word;
  logic          hs;
  logic          word_done;

  logic [SW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;

  assign hs        = o_axis_tvalid && i_axis_tready;
  assign word_done = hs && (o_axis_tuser == CH_LAST);
  assign ch_nxt    = o_axis_tuser + UW'(1);
  assign nxt_word  = set_q[int'(ch_nxt)*Z +: Z];
  assign frame_nxt = !word_done ? frame_cnt :
                     (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);

  assign full  = (o_fifo_level == LW'(FIFO_DEPTH));
  assign empty = (o_fifo_level == '0);
  assign pop   = !soft_clr && !empty && (state == S_IDLE || word_done);
  assign push  = !soft_clr && dec_vld && (!full || pop);

  always_ff @(posedge i_sys_clock) begin
    if (push) mem[wptr] <= dec_set;
  end

  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n || soft_clr) begin
      wptr         <= '0;
      rptr         <= '0;
      o_fifo_level <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      o_fifo_level <= o_fifo_level + LW'(push) - LW'(pop);
      if (dec_vld && full && !pop) o_overflow <= 1'b1;
    end
  end

  // Loading straight from IDLE keeps the empty-FIFO latency at two edges
  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n || soft_clr) begin
      state         <= S_IDLE;
      set_q         <= '0;
      frame_cnt     <= '0;
      o_axis_tvalid <= 1'b0;
      o_axis_tdata  <= '0;
      o_axis_tuser  <= '0;
      o_axis_tlast  <= 1'b0;
    end else begin
      if (word_done) frame_cnt <= frame_nxt;
      if (pop) begin
        state         <= S_SEND;
        set_q         <= mem[rptr];
        o_axis_tvalid <= 1'b1;
        o_axis_tdata  <= sext(mem[rptr][Z-1:0]);
        o_axis_tuser  <= '0;
        o_axis_tlast  <= ONE_CH && (frame_nxt == FRAME_LAST);
      end else if (word_done) begin
        state         <= S_IDLE;
        o_axis_tvalid <= 1'b0;
        o_axis_tlast  <= 1'b0;
      end else if (hs) begin
        o_axis_tuser <= ch_nxt;
        o_axis_tdata <= sext(nxt_word);
        o_axis_tlast <= (ch_nxt == CH_LAST) && (frame_nxt == FRAME_LAST);
      end
    end
  end

endmodule

// File: tb/tb_adc_multichannel_stream.sv
// Randomised bench for adc_multichannel_stream with an averaging
// scoreboard model (N=2, window of 4, 16-set FIFO, 4-set frames).
module tb_adc_multichannel_stream;

  localparam int WIN   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  iagc = 4'h5;
  logic [27:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        clip_clear = 1'b0;
  logic [31:0] tdata;
  logic        tuser;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic [1:0]  clip;
  logic        overflow;
  logic [4:0]  level;

  always #5 clk = ~clk;

  adc_multichannel_stream #(
    .N_CHANNELS(2), .ZMOD_DATA_SIZE(14), .AXIS_DATA_SIZE(32),
    .DECIM_LOG2(2), .FIFO_DEPTH(DEPTH), .FRAME_SETS(4),
    .IAGC_STATUS_SIZE(4)
  ) dut (
    .i_sys_clock(clk), .i_reset_n(rst_n), .i_iagc_status(iagc),
    .i_adc_data(adc_data), .i_adc_valid(adc_valid),
    .i_clip_clear(clip_clear), .o_axis_tdata(tdata),
    .o_axis_tuser(tuser), .o_axis_tvalid(tvalid),
    .i_axis_tready(tready), .o_axis_tlast(tlast), .o_clip(clip),
    .o_overflow(overflow), .o_fifo_level(level)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } word_t;

  word_t expq[$];
  word_t prev_w;
  logic  prev_stall = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    acc0, acc1, win, nset, n_last, cap, rdy_mode;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int floor_avg(int s);
    return (s >= 0) ? s / WIN : -((-s + WIN - 1) / WIN);
  endfunction

  function automatic int rnd();
    return int'($urandom_range(16000)) - 8000;
  endfunction

  task automatic model_reset();
    expq.delete();
    acc0 = 0; acc1 = 0; win = 0; nset = 0;
  endtask

  task automatic model_sample(int s0, int s1);
    acc0 += s0;
    acc1 += s1;
    win++;
    if (win == WIN) begin
      if (cap != 0) begin
        if (cap > 0) cap--;
        expq.push_back('{d: 32'(floor_avg(acc0)), u: 1'b0, l: 1'b0});
        expq.push_back('{d: 32'(floor_avg(acc1)), u: 1'b1,
                         l: (nset % 4 == 3)});
        nset++;
      end
      acc0 = 0; acc1 = 0; win = 0;
    end
  endtask

  task automatic cycle();
    word_t w;
    case (rdy_mode)
      0: tready = 1'b0;
      1: tready = 1'b1;
      default: tready = 1'($urandom % 2);
    endcase
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", tvalid, 1);
      chk("hold_data", tdata, prev_w.d);
      chk("hold_user", tuser, prev_w.u);
      chk("hold_last", tlast, prev_w.l);
    end
    if (tvalid && tready) begin
      if (expq.size() == 0) begin
        chk("extra_word", tvalid, 0);
      end else begin
        w = expq.pop_front();
        chk("tdata", tdata, w.d);
        chk("tuser", tuser, w.u);
        chk("tlast", tlast, w.l);
        if (tlast) n_last++;
      end
    end
    prev_stall = tvalid && !tready;
    prev_w = '{d: tdata, u: tuser, l: tlast};
    @(posedge clk);
    #1;
  endtask

  task automatic send(int s0, int s1);
    adc_data = {14'(s1), 14'(s0)};
    adc_valid = 1'b1;
    cycle();
    adc_valid = 1'b0;
    model_sample(s0, s1);
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 600 && (expq.size() != 0 || tvalid); i++)
      cycle();
    chk("drain_left", 32'(expq.size()), 0);
    chk("drain_tvalid", tvalid, 0);
  endtask

  task automatic soft_clear();
    rdy_mode = 0;
    iagc = 4'h0;
    cycle();
    iagc = 4'h5;
    prev_stall = 1'b0;
    model_reset();
  endtask

  initial begin
    rdy_mode = 0;
    cap = -1;
    n_last = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_clip", clip, 0);
    rst_n = 1'b1;

    rdy_mode = 1;
    repeat (4) send(100, -5);
    chk("lat_k_valid", tvalid, 0);
    cycle();
    chk("lat_k1_level", level, 1);
    chk("lat_k1_valid", tvalid, 0);
    cycle();
    chk("lat_k2_valid", tvalid, 1);
    chk("lat_k2_data", tdata, 100);
    chk("lat_k2_user", tuser, 0);
    drain();

    send(1, 0); send(2, 0); send(3, 0);
    repeat (4) cycle();
    chk("early_valid", tvalid, 0);
    chk("early_level", level, 0);
    send(-7, 0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 2 == 1) send(rnd(), rnd());
      else cycle();
    end
    drain();
    chk("rand_ovf", overflow, 0);

    soft_clear();
    rdy_mode = 1;
    n_last = 0;
    repeat (8 * WIN) send(rnd(), rnd());
    drain();
    chk("frame_tlast_cnt", n_last, 2);

    soft_clear();
    cap = DEPTH + 1;
    rdy_mode = 0;
    repeat (20 * WIN) send(rnd(), rnd());
    repeat (3) cycle();
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    cap = -1;
    drain();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_level0", level, 0);

    soft_clear();
    chk("sc_ovf", overflow, 0);
    rdy_mode = 1;
    send(0, 8191);
    chk("clip_set", clip, 2'b10);
    clip_clear = 1'b1;
    cycle();
    clip_clear = 1'b0;
    chk("clip_clr", clip, 0);
    clip_clear = 1'b1;
    send(-8192, 0);
    clip_clear = 1'b0;
    chk("clip_win", clip, 2'b01);
    clip_clear = 1'b1;
    send(5, 5);
    clip_clear = 1'b0;
    chk("clip_clr2", clip, 0);
    send(1, 1);
    drain();

    rdy_mode = 1;
    repeat (WIN) send(rnd(), rnd());
    for (int i = 0; i < 10 && !(tvalid && tuser == 1'b1); i++) cycle();
    chk("mid_reached", tuser, 1);
    soft_clear();
    chk("mid_tvalid", tvalid, 0);
    chk("mid_level", level, 0);
    chk("mid_tlast", tlast, 0);

    rdy_mode = 2;
    repeat (30) send(rnd(), rnd());
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", tvalid, 0);
    chk("arst_tdata", tdata, 0);
    chk("arst_tuser", tuser, 0);
    chk("arst_tlast", tlast, 0);
    chk("arst_level", level, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_clip", clip, 0);
    prev_stall = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 1;
    repeat (5) cycle();
    chk("post_rst_valid", tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
